// File: rtl/mips_intr_ctrl.sv
// Priority interrupt controller: latches edge requests, masks them, and runs the
// CPU intr/inta handshake, holding further interrupts off until software writes EOI.
module mips_intr_ctrl #(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [7:0]  MASK_RST = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq,
  output logic        intr,
  input  logic        inta,
  input  logic        io_cs,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [1:0]  io_addr,
  input  logic [31:0] io_d_in,
  output logic [31:0] io_d_out,
  output logic        in_service
);

  localparam int unsigned IRQ_W = 8;
  localparam int unsigned ID_W  = 3;
  localparam logic [IRQ_W-1:0] IRQ_VALID = IRQ_W'((9'd1 << NUM_IRQ) - 9'd1);

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_VEC  = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t            state;
  logic [IRQ_W-1:0]  pend;
  logic [IRQ_W-1:0]  mask;
  logic [IRQ_W-1:0]  irq_q;
  logic              inta_q;
  logic [ID_W-1:0]   isr_id;

  logic [IRQ_W-1:0]  irq_rise;
  logic [IRQ_W-1:0]  active;
  logic [IRQ_W-1:0]  pend_nxt;
  logic [ID_W-1:0]   sel;
  logic              wr_en;
  logic              eoi_wr;
  logic              inta_rise;
  logic              ack;

  assign wr_en     = io_cs & io_wr;
  assign eoi_wr    = wr_en & (io_addr == ADDR_EOI);
  assign irq_rise  = irq & ~irq_q & IRQ_VALID;
  assign inta_rise = inta & ~inta_q;
  assign active    = pend & mask;
  assign ack       = (state == ST_REQ) & (|active) & inta_rise;

  // Lowest-index active source wins
  always_comb begin
    sel = '0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (active[i]) sel = ID_W'(i);
    end
  end

  // New edges are applied last so they override both W1C and the ack clear
  always_comb begin
    pend_nxt = pend;
    if (wr_en && (io_addr == ADDR_PEND)) pend_nxt = pend_nxt & ~io_d_in[IRQ_W-1:0];
    if (ack) pend_nxt[sel] = 1'b0;
    pend_nxt = (pend_nxt | irq_rise) & IRQ_VALID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q  <= '0;
      inta_q <= 1'b0;
      pend   <= '0;
      mask   <= MASK_RST & IRQ_VALID;
    end else begin
      irq_q  <= irq & IRQ_VALID;
      inta_q <= inta;
      pend   <= pend_nxt;
      if (wr_en && (io_addr == ADDR_MASK)) mask <= io_d_in[IRQ_W-1:0] & IRQ_VALID;
    end
  end

  // Handshake sequencer with registered intr / in_service
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      intr       <= 1'b0;
      in_service <= 1'b0;
      isr_id     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|active) begin
            state <= ST_REQ;
            intr  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (!(|active)) begin
            state <= ST_IDLE;
            intr  <= 1'b0;
          end else if (inta_rise) begin
            state      <= ST_SERVICE;
            intr       <= 1'b0;
            in_service <= 1'b1;
            isr_id     <= sel;
          end
        end
        ST_SERVICE: begin
          if (eoi_wr) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          intr       <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    io_d_out = '0;
    if (io_cs && io_rd) begin
      case (io_addr)
        ADDR_MASK: io_d_out = {24'b0, mask};
        ADDR_PEND: io_d_out = {24'b0, pend};
        ADDR_VEC:  io_d_out = {in_service, 28'b0, isr_id};
        default:   io_d_out = '0;
      endcase
    end
  end

endmodule

// File: doc/mips_intr_ctrl.md
Name: mips_intr_ctrl

Overview:
- Priority interrupt controller that sequences the CPU's single interrupt line (intr) and acknowledge (inta) handshake.
- Latches edge-triggered requests from up to 8 peripheral sources and masks them.
- Selects the highest-priority source, raises intr, and latches the serviced source ID on inta.
- Holds off further interrupts until software writes end-of-interrupt (EOI) through the IO memory port. Sits beside the IO memory on the CPU's io_cs/io_rd/io_wr bus.

Parameters:
- NUM_IRQ, 8, number of request inputs used (1..8); inputs above NUM_IRQ-1 are ignored and their register bits read 0.
- MASK_RST, 8'h00, reset value of the enable mask (1 = enabled).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- irq  in  8  peripheral requests, synchronous to clk, rising-edge sensitive
- intr  out  1  interrupt request to CPU, registered
- inta  in  1  interrupt acknowledge from CPU, level; the rising edge is used
- io_cs  in  1  register-block select
- io_rd  in  1  read strobe, qualified by io_cs
- io_wr  in  1  write strobe, qualified by io_cs
- io_addr  in  2  register select (word index, CPU address bits [3:2])
- io_d_in  in  32  write data
- io_d_out  out  32  read data, combinational from registers; 32'h0 when not (io_cs & io_rd)
- in_service  out  1  high while a source is being serviced (SERVICE state)

Behaviour:
- Reset (async): pend=0, mask=MASK_RST, irq_q=0, inta_q=0, isr_id=0, state=IDLE, intr=0, in_service=0.
- Edge detect: irq_q<=irq every cycle. pend[i] sets at the edge where irq[i]=1 and irq_q[i]=0, so the bit is visible the cycle after irq rises. A level held high sets pend only once.
- Register map (io_addr):
  - 0 MASK: RW, bits[7:0], upper bits read 0.
  - 1 PEND: R, bits[7:0]. A write clears the pend bits whose io_d_in bits are 1 (W1C).
  - 2 VECTOR: R, {in_service, 28'b0, isr_id[2:0]}. Writes ignored.
  - 3 EOI: W, any write data. Reads 0.
- Same-cycle set and W1C on one bit: set wins, bit stays 1.
- Selection: active = pend & mask. sel = lowest-index set bit of active (bit 0 highest priority).
- State machine:
  - IDLE: intr=0. If active!=0, go to REQ at the next edge; intr registers high on that same edge, so latency is irq rise -> pend +1 cycle -> intr +1 cycle.
  - REQ: intr=1. sel is re-evaluated every cycle, so a higher-priority arrival preempts before ack. If active becomes 0 (mask write or W1C), return to IDLE with intr=0 at the next edge. On the inta rising edge (inta=1, inta_q=0): isr_id<=sel, pend[sel]<=0, state<=SERVICE, intr<=0, all at the same edge.
  - SERVICE: intr=0, in_service=1, and other pending sources stay latched. An EOI write moves the block to IDLE at the next edge. If active!=0, IDLE re-raises intr one cycle later. isr_id holds its value after EOI until the next ack.
- Ignored events:
  - inta rising edge in IDLE or SERVICE (spurious): ignored, no state change.
  - EOI write in IDLE or REQ: ignored.
- Simultaneous events:
  - An edge on the source being acknowledged in the ack cycle re-sets its pend bit (set wins over the ack clear).
  - A W1C of sel in the same cycle as the inta edge: ack proceeds with that sel.
- Reset asserted mid-operation (any state): immediate return to reset values. Pending requests are lost.

Test Plan:
1. Reset, write MASK=8'h0F, pulse irq[2] for 1 cycle -> PEND reads 8'h04, intr high 2 cycles after irq rise; raise inta -> next cycle intr=0, in_service=1, VECTOR reads 32'h8000_0002, PEND reads 0.
2. With MASK=8'hFF, raise irq[5] and irq[1] in the same cycle, then ack -> isr_id=1, PEND=8'h20. Write EOI -> intr re-asserts within 2 cycles; ack -> isr_id=5.
3. MASK=8'h00, pulse irq[3] -> PEND=8'h08, intr stays 0. Write MASK=8'h08 -> intr=1 two cycles after the write. Write MASK=0 before inta -> intr falls, state returns to IDLE, PEND still 8'h08.
4. In REQ with pend=8'h10, raise irq[0] -> sel switches to 0; ack yields isr_id=0 and PEND=8'h10.
5. Spurious inta in IDLE and EOI write in IDLE -> no change to intr, PEND, or VECTOR. Hold irq[4] high for 10 cycles -> exactly one pend set.
6. Assert reset while in SERVICE with PEND=8'h81 -> intr=0, in_service=0, PEND=0, MASK=MASK_RST, immediately (asynchronously).
